data_memory_pipe: RTL and testbench
===================================

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits; integer multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 512, number of words; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, width of the word-index address port.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  word index.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port req_be  input  DATA_WIDTH/8  byte enables; bit k selects byte k (bits 8k+7:8k).
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err  output  1  request address was out of range.
REQ-016 SHALL have port init_done  output  1  memory clear complete.

Function
REQ-017 SHALL implement two states, INIT and RUN; reset enters INIT.
REQ-018 In INIT, SHALL write zero to one word per cycle, from index 0 through DEPTH-1, using an internal counter.
REQ-019 SHALL move from INIT to RUN on the cycle after word DEPTH-1 is cleared; the total clear time SHALL be exactly DEPTH cycles.
REQ-020 init_done SHALL be 0 in INIT and 1 in RUN.
REQ-021 req_ready SHALL be 0 in INIT; requests presented during INIT are not accepted and have no effect.
REQ-022 In RUN, req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally.
REQ-023 Response latency SHALL be one cycle: a request accepted at edge N sets rsp_valid after edge N, with its data and err.
REQ-024 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-025 rsp_valid SHALL clear on a consuming edge with no new accept; consume plus accept in the same cycle SHALL keep rsp_valid at 1 with the new response (full throughput).
REQ-026 Read: rsp_rdata SHALL be mem[req_addr] as of before the accept edge, and rsp_err SHALL be 0.
REQ-027 Write: SHALL update only the bytes whose req_be bit is 1; rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-028 A write with req_be all zeros SHALL leave memory unchanged and SHALL still produce a response.
REQ-029 If req_addr >= DEPTH, SHALL perform no memory access, and the response SHALL be rsp_rdata = 0, rsp_err = 1.
REQ-030 The address SHALL NOT wrap: the full ADDR_WIDTH value is compared against DEPTH.
REQ-031 A read accepted in the cycle immediately after a write to the same address SHALL return the written data (no stale read).

Reset
REQ-032 While rst_n = 0, SHALL force: rsp_valid 0, rsp_rdata 0, rsp_err 0, init_done 0, req_ready 0, state INIT, clear counter 0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL discard any pending response and restart the full DEPTH-cycle clear after deassertion.
REQ-034 Memory array contents are not reset directly; they SHALL be all zero once init_done = 1.

Verification
REQ-035 Reset then idle, DEPTH=512 -> init_done rises exactly 512 cycles after rst_n deasserts; req_ready stays 0 until then.
REQ-036 Write addr 1, data 0xDEADBEEF, be 0xF, then read addr 1 -> write response rdata 0 / err 0; read response 0xDEADBEEF next cycle.
REQ-037 Write addr 0, data 0x11223344, be 0b0101, over the cleared word, then read addr 0 -> 0x00220044.
REQ-038 Read addr 512 with DEPTH=512 -> rsp_err 1, rsp_rdata 0, and no word in memory changes.
REQ-039 Back-to-back reads of addresses 0 to 7 with rsp_ready held low for 3 cycles mid-stream -> req_ready drops and the response stays stable; there is no loss or duplication, and the data order matches.
REQ-040 Pulse rst_n low during RUN with rsp_valid = 1 -> rsp_valid drops immediately, a full INIT repeats, and a read of the previously written addr 1 returns 0.

Source files
------------

// File: rtl/data_memory_pipe.sv
// Word-addressed data memory with byte enables and a one-deep response register.
// After reset the array is cleared one word per cycle before requests are accepted.
module data_memory_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    init_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                  state, state_next;
    logic [AW-1:0]           clr_cnt, clr_cnt_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           idx;
    logic                    in_range;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Full-width compare so out-of-range addresses never alias onto low words.
    assign in_range  = 64'(req_addr) < 64'(DEPTH);
    assign idx       = req_addr[AW-1:0];
    assign rd_word   = mem[idx];
    assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign init_done = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            INIT: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_next   = RUN;
                    clr_cnt_next = '0;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next   = INIT;
                clr_cnt_next = '0;
            end
        endcase
    end

    // Array has no reset; the INIT sweep is what guarantees zero contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_cnt] <= '0;
        end else if (accept && req_we && in_range) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (req_be[k]) begin
                    mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
            rsp_rdata <= (!req_we && in_range) ? rd_word : '0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: clear timing, byte writes, range errors,
// backpressure streaming and reset during RUN.
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    data_memory_pipe #(
        .DATA_WIDTH(32),
        .DEPTH(512),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with rsp_ready high; returns the response seen after the accept edge.
    task automatic single(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic v, output logic [31:0] d,
                          output logic e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        v = rsp_valid; d = rsp_rdata; e = rsp_err;
    endtask

    // Counts edges from rst_n release until init_done; req_ready must stay low meanwhile.
    task automatic wait_init(output int n);
        n = 0;
        rst_n = 1'b1;
        while (n < 2000) begin
            tick();
            n++;
            if (init_done) break;
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_during_init cycle=%0d got=%b exp=0", n, req_ready);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd3;
        req_wdata = 32'hFFFF_FFFF; req_be = 4'hF; rsp_ready = 1'b1;
        repeat (3) tick();
        total++;
        if ({rsp_valid, rsp_err, init_done, req_ready} !== 4'b0000 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got v/e/d/r=%b%b%b%b rdata=%h exp=0000 rdata=0",
                     rsp_valid, rsp_err, init_done, req_ready, rsp_rdata);
        end
        // The pending write to addr 3 is presented throughout INIT and must be ignored.
        wait_init(n);
        total++;
        if (n !== 512 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL init_length got=%0d done=%b exp=512 done=1", n, init_done);
        end
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_rsp_after_init got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_write_read();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd1; req_wdata = 32'hDEAD_BEEF;
        req_be = 4'hF; rsp_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL write_rsp got v=%b d=%h e=%b exp v=1 d=0 e=0", rsp_valid, rsp_rdata, rsp_err);
        end
        req_we = 1'b0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL read_after_write got v=%b d=%h e=%b exp v=1 d=deadbeef e=0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        req_valid = 1'b0;
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_clears got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_byte_enable();
        logic v, e;
        logic [31:0] d;
        single(1'b1, 32'd0, 32'h1122_3344, 4'b0101, v, d, e);
        single(1'b0, 32'd0, 32'h0, 4'h0, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0022_0044 || e !== 1'b0) begin
            bad++;
            $display("FAIL byte_enable got v=%b d=%h e=%b exp v=1 d=00220044 e=0", v, d, e);
        end
        single(1'b1, 32'd1, 32'hFFFF_FFFF, 4'b0000, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
            bad++;
            $display("FAIL be_zero_rsp got v=%b d=%h e=%b exp v=1 d=0 e=0", v, d, e);
        end
        single(1'b0, 32'd1, 32'h0, 4'h0, v, d, e);
        total++;
        if (d !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL be_zero_unchanged got=%h exp=deadbeef", d);
        end
        single(1'b0, 32'd3, 32'h0, 4'h0, v, d, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL init_req_ignored got=%h exp=0", d);
        end
    endtask

    task automatic test_out_of_range();
        logic v, e;
        logic [31:0] d;
        single(1'b0, 32'd512, 32'h0, 4'h0, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
            bad++;
            $display("FAIL oor_read got v=%b d=%h e=%b exp v=1 d=0 e=1", v, d, e);
        end
        single(1'b1, 32'd512, 32'hAAAA_AAAA, 4'hF, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
            bad++;
            $display("FAIL oor_write got v=%b d=%h e=%b exp v=1 d=0 e=1", v, d, e);
        end
        single(1'b1, 32'h8000_0001, 32'h5555_5555, 4'hF, v, d, e);
        total++;
        if (e !== 1'b1) begin
            bad++;
            $display("FAIL oor_high_err got=%b exp=1", e);
        end
        single(1'b0, 32'd0, 32'h0, 4'h0, v, d, e);
        total++;
        if (d !== 32'h0022_0044 || e !== 1'b0) begin
            bad++;
            $display("FAIL oor_no_alias0 got d=%h e=%b exp d=00220044 e=0", d, e);
        end
        single(1'b0, 32'd1, 32'h0, 4'h0, v, d, e);
        total++;
        if (d !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL oor_no_alias1 got=%h exp=deadbeef", d);
        end
    endtask

    task automatic test_back_to_back();
        logic v, e;
        logic [31:0] d;
        int issued = 0;
        int recv = 0;
        int cyc = 0;
        logic mvalid = 1'b0;
        logic [31:0] mdata = 32'h0;
        logic exp_ready, acc, cons;
        for (int i = 0; i < 8; i++) single(1'b1, 32'(i), 32'h1000_0000 + 32'(i), 4'hF, v, d, e);
        tick();
        while (recv < 8 && cyc < 50) begin
            req_valid = (issued < 8); req_we = 1'b0; req_addr = 32'(issued);
            rsp_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            exp_ready = !mvalid || rsp_ready;
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
            end
            acc  = req_valid && exp_ready;
            cons = mvalid && rsp_ready;
            if (cons) recv++;
            @(posedge clk);
            #1;
            if (acc) begin
                mvalid = 1'b1; mdata = 32'h1000_0000 + 32'(issued); issued++;
            end else if (cons) begin
                mvalid = 1'b0;
            end
            total++;
            if (rsp_valid !== mvalid || (mvalid && (rsp_rdata !== mdata || rsp_err !== 1'b0))) begin
                bad++;
                $display("FAIL b2b_rsp cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         cyc, rsp_valid, rsp_rdata, mvalid, mdata);
            end
            cyc++;
        end
        total++;
        if (recv !== 8 || issued !== 8 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got recv=%0d issued=%0d v=%b exp 8 8 0", recv, issued, rsp_valid);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic v, e;
        logic [31:0] d;
        int n;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd1; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1000_0001) begin
            bad++;
            $display("FAIL pre_reset_rsp got v=%b d=%h exp v=1 d=10000001", rsp_valid, rsp_rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got v=%b d=%h done=%b rdy=%b exp 0 0 0 0",
                     rsp_valid, rsp_rdata, init_done, req_ready);
        end
        rsp_ready = 1'b1;
        tick();
        wait_init(n);
        total++;
        if (n !== 512 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL reinit_length got=%0d done=%b exp=512 done=1", n, init_done);
        end
        single(1'b0, 32'd1, 32'h0, 4'h0, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
            bad++;
            $display("FAIL reinit_cleared got v=%b d=%h e=%b exp v=1 d=0 e=0", v, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
